// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and helpers for the ALU request arbiter.
// Holds the FSM state enum, multiply command codes and flag indices.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   localparam int CMD_MUL_INC = 9;
   localparam int CMD_MUL_SHL = 10;

   localparam int FLG_ERR   = 5;
   localparam int FLG_OFLOW = 4;
   localparam int FLG_COUT  = 3;
   localparam int FLG_G     = 2;
   localparam int FLG_L     = 1;
   localparam int FLG_E     = 0;

   // Multiply commands only exist in arithmetic mode.
   function automatic logic is_mul(input logic mode,
                                   input logic [15:0] cmd);
      return mode &&
             ((cmd == 16'(CMD_MUL_INC)) ||
              (cmd == 16'(CMD_MUL_SHL)));
   endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: 2-way grant logic for the ALU request arbiter.
// ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins).
module alu_rr_arbiter (
   input  logic       CLK,
   input  logic       RST,
   input  logic       en,
   input  logic [1:0] req,
   input  logic       adv,
   input  logic       nxt,
   output logic [1:0] gnt
);

   logic ptr;

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic unused_ok;
   assign unused_ok = ^{CLK, RST, adv, nxt};
   assign ptr = 1'b0;
`else
   // Priority pointer moves when a response is accepted.
   always_ff @(posedge CLK) begin
      if (RST)
         ptr <= 1'b0;
      else if (adv)
         ptr <= nxt;
   end
`endif

   // Preferred requester first, the other as fallback.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (ptr == 1'b0)
            gnt = req[0] ? 2'b01 :
                  req[1] ? 2'b10 : 2'b00;
         else
            gnt = req[1] ? 2'b10 :
                  req[0] ? 2'b01 : 2'b00;
      end
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered ALU between two requesters.
// Build option ALU_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin.
module alu_req_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CMD_WIDTH = 4,
   parameter int STD_LAT   = 1,
   parameter int MUL_LAT   = 2
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0]             req_mode,
   input  logic [2*CMD_WIDTH-1:0] req_cmd,
   input  logic [2*WIDTH-1:0]     req_opa,
   input  logic [2*WIDTH-1:0]     req_opb,
   input  logic [1:0]             req_cin,
   input  logic [3:0]             req_inp_valid,
   output logic                   alu_ce,
   output logic                   alu_mode,
   output logic [CMD_WIDTH-1:0]   alu_cmd,
   output logic [WIDTH-1:0]       alu_opa,
   output logic [WIDTH-1:0]       alu_opb,
   output logic                   alu_cin,
   output logic [1:0]             alu_inp_valid,
   input  logic [WIDTH:0]         alu_res,
   input  logic [5:0]             alu_flags,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_id,
   output logic [WIDTH:0]         rsp_res,
   output logic [5:0]             rsp_flags
);

   localparam int LW = 4;

   state_t        state;
   logic [LW-1:0] lat_cnt;
   logic          id_r;
   logic [1:0]    gnt;
   logic          gid;
   logic          hs;
   logic          rr_en;
   logic          rr_adv;

   assign rr_en  = (state == IDLE) && !RST;
   assign rr_adv = (state == RESP) && rsp_ready;

   alu_rr_arbiter u_rr (
      .CLK (CLK),
      .RST (RST),
      .en  (rr_en),
      .req (req_valid),
      .adv (rr_adv),
      .nxt (~rsp_id),
      .gnt (gnt)
   );

   assign req_ready = gnt;
   assign gid       = gnt[1];
   assign hs        = |(req_valid & gnt);

   // Issue/wait/respond sequencing; the alu_* registers hold the
   // latched request while it is presented to the ALU.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         lat_cnt       <= '0;
         id_r          <= 1'b0;
         alu_ce        <= 1'b0;
         alu_mode      <= 1'b0;
         alu_cmd       <= '0;
         alu_opa       <= '0;
         alu_opb       <= '0;
         alu_cin       <= 1'b0;
         alu_inp_valid <= 2'b00;
         rsp_valid     <= 1'b0;
         rsp_id        <= 1'b0;
         rsp_res       <= '0;
         rsp_flags     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (hs) begin
                  id_r     <= gid;
                  alu_ce   <= 1'b1;
                  alu_mode <= req_mode[gid];
                  alu_cin  <= req_cin[gid];
                  alu_cmd  <= gid ? req_cmd[CMD_WIDTH +: CMD_WIDTH]
                                  : req_cmd[0 +: CMD_WIDTH];
                  alu_opa  <= gid ? req_opa[WIDTH +: WIDTH]
                                  : req_opa[0 +: WIDTH];
                  alu_opb  <= gid ? req_opb[WIDTH +: WIDTH]
                                  : req_opb[0 +: WIDTH];
                  alu_inp_valid <= gid ? req_inp_valid[3:2]
                                       : req_inp_valid[1:0];
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               lat_cnt <= is_mul(alu_mode, 16'(alu_cmd)) ?
                          LW'(MUL_LAT) : LW'(STD_LAT);
               alu_ce        <= 1'b0;
               alu_mode      <= 1'b0;
               alu_cmd       <= '0;
               alu_opa       <= '0;
               alu_opb       <= '0;
               alu_cin       <= 1'b0;
               alu_inp_valid <= 2'b00;
               state         <= WAIT;
            end
            WAIT: begin
               lat_cnt <= lat_cnt - LW'(1);
               if (lat_cnt == LW'(1)) begin
                  rsp_res   <= alu_res;
                  rsp_flags <= alu_flags;
                  rsp_id    <= id_r;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
